// File: rtl/cpu_operand_pkg.sv
// Shared constants for the operand-select datapath: source indices,
// the zero-select code and default sizing.
package cpu_operand_pkg;
    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_NUM_SRC = 4;

    localparam int SRC_RS1 = 0;
    localparam int SRC_RS2 = 1;
    localparam int SRC_IMM = 2;
    localparam int SRC_FWD = 3;

    // Any select at or above this code yields an all-zero operand.
    localparam int SEL_ZERO = DEFAULT_NUM_SRC;

    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction
endpackage

// File: rtl/operand_select_stage_if.sv
// Request/response bundle between register-read, the operand stage and execute.
interface operand_select_stage_if
    import cpu_operand_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel_a;
    logic [SEL_W-1:0]         sel_b;
    logic                     in_valid;
    logic                     in_ready;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         operand_a;
    logic [WIDTH-1:0]         operand_b;
    logic [1:0]               occupancy;

    modport master (
        output src_data, sel_a, sel_b, in_valid, flush, out_ready,
        input  in_ready, out_valid, operand_a, operand_b, occupancy
    );

    modport slave (
        input  src_data, sel_a, sel_b, in_valid, flush, out_ready,
        output in_ready, out_valid, operand_a, operand_b, occupancy
    );
endinterface

// File: rtl/operand_source_mux.sv
// Combinational N-way operand selector; out-of-range select codes give zero.
module operand_source_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         operand
);
    logic [WIDTH-1:0] src_arr [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        operand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) operand = src_arr[i];
        end
    end
endmodule

// File: rtl/operand_select_stage.sv
// Selects ALU operands A/B and registers them behind a 2-entry skid buffer
// (main register M drives the outputs, skid register S catches one stall).
module operand_select_stage
    import cpu_operand_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_SRC = DEFAULT_NUM_SRC,
    parameter int SEL_W   = $clog2(NUM_SRC + 1)
) (
    input logic                  clk,
    input logic                  reset,
    operand_select_stage_if.slave bus
);
    logic [WIDTH-1:0] sel_a_data;
    logic [WIDTH-1:0] sel_b_data;

    operand_source_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux_a (
        .src_data (bus.src_data),
        .sel      (bus.sel_a),
        .operand  (sel_a_data)
    );

    operand_source_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux_b (
        .src_data (bus.src_data),
        .sel      (bus.sel_b),
        .operand  (sel_b_data)
    );

    logic             m_valid_reg, m_valid_next;
    logic             s_valid_reg, s_valid_next;
    logic [WIDTH-1:0] m_a_reg, m_a_next, m_b_reg, m_b_next;
    logic [WIDTH-1:0] s_a_reg, s_a_next, s_b_reg, s_b_next;
    logic             accept;
    logic             m_free;

    // Ready depends only on state, so out_ready never reaches in_ready.
    assign accept = bus.in_valid && !s_valid_reg;
    assign m_free = !m_valid_reg || bus.out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        s_valid_next = s_valid_reg;
        m_a_next     = m_a_reg;
        m_b_next     = m_b_reg;
        s_a_next     = s_a_reg;
        s_b_next     = s_b_reg;
        if (bus.flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (m_free) begin
            if (s_valid_reg) begin
                // No accept is possible here: in_ready is low while S holds data.
                m_valid_next = 1'b1;
                s_valid_next = 1'b0;
                m_a_next     = s_a_reg;
                m_b_next     = s_b_reg;
            end else if (accept) begin
                m_valid_next = 1'b1;
                m_a_next     = sel_a_data;
                m_b_next     = sel_b_data;
            end else begin
                m_valid_next = 1'b0;
            end
        end else if (accept) begin
            s_valid_next = 1'b1;
            s_a_next     = sel_a_data;
            s_b_next     = sel_b_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_a_reg     <= '0;
            m_b_reg     <= '0;
            s_a_reg     <= '0;
            s_b_reg     <= '0;
        end else begin
            m_valid_reg <= m_valid_next;
            s_valid_reg <= s_valid_next;
            m_a_reg     <= m_a_next;
            m_b_reg     <= m_b_next;
            s_a_reg     <= s_a_next;
            s_b_reg     <= s_b_next;
        end
    end

    assign bus.in_ready  = !s_valid_reg;
    assign bus.out_valid = m_valid_reg;
    assign bus.operand_a = m_a_reg;
    assign bus.operand_b = m_b_reg;
    assign bus.occupancy = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};
endmodule

// File: tb/tb_operand_select_stage.sv
// Randomised and directed checks of operand_select_stage against a queue-based
// model of a 2-deep FIFO holding selected operand pairs.
module tb_operand_select_stage;
    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 4;
    localparam int SEL_W   = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_select_stage_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) tif ();

    operand_select_stage #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] q[$];
    logic [63:0] last_pair = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] pick(input logic [NUM_SRC*WIDTH-1:0] src,
                                              input logic [SEL_W-1:0] sel);
        if (int'(sel) < NUM_SRC) return src[int'(sel)*WIDTH +: WIDTH];
        return '0;
    endfunction

    // Bounded FIFO: accept only while fewer than two pairs are held; the head
    // is what the outputs show, and they keep the last head once it leaves.
    task automatic model_edge();
        bit acc;
        if (tif.flush) begin
            q.delete();
        end else begin
            acc = tif.in_valid && (q.size() < 2);
            if (q.size() > 0 && tif.out_ready) void'(q.pop_front());
            if (acc) q.push_back({pick(tif.src_data, tif.sel_a), pick(tif.src_data, tif.sel_b)});
        end
        if (q.size() > 0) last_pair = q[0];
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 64'(tif.out_valid), 64'(q.size() > 0));
        check_eq("in_ready", 64'(tif.in_ready), 64'(q.size() < 2));
        check_eq("occupancy", 64'(tif.occupancy), 64'(q.size()));
        check_eq("operand_a", 64'(tif.operand_a), 64'(last_pair[63:32]));
        check_eq("operand_b", 64'(tif.operand_b), 64'(last_pair[31:0]));
        $display("cyc t=%0t v=%0b a=%08h b=%08h occ=%0d rdy=%0b", $time,
                 tif.out_valid, tif.operand_a, tif.operand_b, tif.occupancy, tif.in_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb,
                         input logic [NUM_SRC*WIDTH-1:0] src);
        tif.in_valid = v;
        tif.sel_a    = sa;
        tif.sel_b    = sb;
        tif.src_data = src;
    endtask

    function automatic logic [NUM_SRC*WIDTH-1:0] rand_src();
        logic [NUM_SRC*WIDTH-1:0] s;
        for (int i = 0; i < NUM_SRC; i++) s[i*WIDTH +: WIDTH] = $urandom;
        return s;
    endfunction

    initial begin
        int sent;
        int cyc;
        int n_acc;
        reset = 1'b0;
        tif.flush = 1'b0;
        tif.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_outputs();

        // Single pass through an empty buffer
        tif.out_ready = 1'b1;
        drive(1'b1, 3'd0, 3'd2, {32'h4, 32'h3, 32'h2, 32'h1});
        tick();
        check_eq("single_valid", 64'(tif.out_valid), 64'd1);
        check_eq("single_a", 64'(tif.operand_a), 64'h1);
        check_eq("single_b", 64'(tif.operand_b), 64'h3);
        tif.in_valid = 1'b0;
        tick();
        check_eq("single_drop", 64'(tif.out_valid), 64'd0);

        // Backpressure: third request must stall, nothing lost or duplicated
        tif.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'd0, 3'd1, {32'h0, 32'h0, 32'hB0 + 32'(k), 32'h10 * 32'(k + 1)});
            tick();
        end
        drive(1'b1, 3'd0, 3'd1, {32'h0, 32'h0, 32'hB2, 32'h30});
        check_eq("bp_ready", 64'(tif.in_ready), 64'd0);
        check_eq("bp_occ", 64'(tif.occupancy), 64'd2);
        check_eq("bp_head", 64'(tif.operand_a), 64'h10);
        tif.out_ready = 1'b1;
        tick();
        check_eq("bp_second", 64'(tif.operand_a), 64'h20);
        tick();
        check_eq("bp_third", 64'(tif.operand_a), 64'h30);
        tif.in_valid = 1'b0;
        tick();

        // Zero select codes
        drive(1'b1, 3'd4, 3'd7, {NUM_SRC*WIDTH{1'b1}});
        tick();
        check_eq("zero_a", 64'(tif.operand_a), 64'h0);
        check_eq("zero_b", 64'(tif.operand_b), 64'h0);
        tif.in_valid = 1'b0;
        tick();

        // Flush with a full buffer, then flush racing an accept
        tif.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'd1, 3'd3, rand_src());
            tick();
        end
        tif.flush = 1'b1;
        drive(1'b1, 3'd0, 3'd0, rand_src());
        tick();
        check_eq("flush_occ", 64'(tif.occupancy), 64'd0);
        check_eq("flush_valid", 64'(tif.out_valid), 64'd0);
        tif.flush = 1'b0;
        tick();
        tif.flush = 1'b1;
        drive(1'b1, 3'd2, 3'd1, rand_src());
        tick();
        check_eq("flush_acc_occ", 64'(tif.occupancy), 64'd0);
        check_eq("flush_acc_ready", 64'(tif.in_ready), 64'd1);
        tif.flush = 1'b0;
        tif.in_valid = 1'b0;
        tick();

        // Asynchronous reset while stalled and full
        tif.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 3'd0, 3'd1, rand_src());
            tick();
        end
        tif.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        q.delete();
        last_pair = '0;
        check_eq("rst_async_occ", 64'(tif.occupancy), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        check_outputs();
        check_eq("rst_ready", 64'(tif.in_ready), 64'd1);

        // Random streaming with 50% backpressure
        sent = 0;
        cyc = 0;
        while (sent < 100 && cyc < 3000) begin
            drive(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 7)),
                  SEL_W'($urandom_range(0, 7)), rand_src());
            tif.out_ready = 1'($urandom_range(0, 1));
            if (tif.in_valid && tif.in_ready) sent++;
            tick();
            cyc++;
        end
        check_eq("stream_sent", 64'(sent), 64'd100);
        tif.in_valid = 1'b0;
        tif.out_ready = 1'b1;
        repeat (3) tick();

        // Full-rate throughput with out_ready held high
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, SEL_W'($urandom_range(0, 4)), SEL_W'($urandom_range(0, 4)), rand_src());
            if (tif.in_ready) n_acc++;
            tick();
            check_eq("thru_valid", 64'(tif.out_valid), 64'd1);
        end
        check_eq("thru_accepts", 64'(n_acc), 64'd20);
        tif.in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
